// File: rtl/bcd_stopwatch_if.sv
// Stopwatch control/display bundle: count controls in, BCD value,
// status and multiplexed 7-segment drive out.
//   master: drives tick_in/start_stop/clear/up_dn, observes the rest
//   slave : the stopwatch itself
interface bcd_stopwatch_if #(
    parameter int DIGITS = 4
);
    logic                  tick_in;
    logic                  start_stop;
    logic                  clear;
    logic                  up_dn;
    logic [4*DIGITS-1:0]   bcd;
    logic                  running;
    logic                  wrap;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;

    modport master (
        output tick_in, start_stop, clear, up_dn,
        input  bcd, running, wrap, an, seg
    );

    modport slave (
        input  tick_in, start_stop, clear, up_dn,
        output bcd, running, wrap, an, seg
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: counts rising edges of tick_in into a DIGITS-wide BCD
// counter and scans it onto a common-anode 7-segment display.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bcd_stopwatch_if
//              (tick_in, start_stop, clear, up_dn -> bcd, running, wrap, an, seg)
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_stopwatch #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input logic             clk,
    input logic             rst,
    bcd_stopwatch_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {STOPPED, RUNNING} state_t;

    state_t            state;
    state_t            state_next;
    logic              tick_q;
    logic              count_evt;
    logic [W-1:0]      bcd_q;
    logic [W-1:0]      bcd_next;
    logic              wrap_q;
    logic              wrap_next;
    logic              carry;
    logic [3:0]        dig;
    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     digit_idx;
    logic [3:0]        cur_digit;
    logic              blank;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // tick_q resets high so a level already high at release is not an edge
    assign count_evt = bus.tick_in & ~tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STOPPED;
            tick_q <= 1'b1;
        end else begin
            state  <= state_next;
            tick_q <= bus.tick_in;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = STOPPED;
        end else if (bus.start_stop) begin
            case (state)
                STOPPED: state_next = RUNNING;
                default: state_next = STOPPED;
            endcase
        end
    end

    // Ripple +/-1 through the digits; carry surviving the top digit is a wrap
    always_comb begin
        bcd_next = bcd_q;
        carry    = 1'b1;
        dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[i*4 +: 4];
            if (carry) begin
                if (bus.up_dn) begin
                    if (dig == 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = 4'd9;
                    end else begin
                        dig   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            bcd_next[i*4 +: 4] = dig;
        end
        wrap_next = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            wrap_q <= 1'b0;
        end else if (bus.clear) begin
            bcd_q  <= '0;
            wrap_q <= 1'b0;
        end else if (count_evt && state == RUNNING) begin
            bcd_q  <= bcd_next;
            wrap_q <= wrap_next;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (digit_idx == IW'(DIGITS - 1))
                digit_idx <= '0;
            else
                digit_idx <= digit_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IW'(i))
                cur_digit = bcd_q[i*4 +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_above;

    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        nz_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= digit_idx && bcd_q[i*4 +: 4] != 4'd0)
                nz_above = 1'b1;
        end
    end

    assign blank = (digit_idx != '0) && !nz_above;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg_q <= 7'b1000000;
        end else begin
            an_q  <= ~(DIGITS'(1) << digit_idx);
            seg_q <= blank ? 7'b1111111 : seg_decode(cur_digit);
        end
    end

    assign bus.bcd     = bcd_q;
    assign bus.running = (state == RUNNING);
    assign bus.wrap    = wrap_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: randomized control sequences
// checked against an integer-count reference model.
module tb_bcd_stopwatch;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 16;
    localparam int MOD      = 10000;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc;

    int   m_count;
    bit   m_run;
    bit   m_wrap;

    logic [6:0] segtab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    always #5 clk = ~clk;

    bcd_stopwatch_if #(.DIGITS(DIGITS)) sw_if ();

    bcd_stopwatch #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    // clock edges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_count();
        if (m_run) begin
            if (sw_if.up_dn) begin
                m_wrap  = (m_count == MOD - 1);
                m_count = (m_count + 1) % MOD;
            end else begin
                m_wrap  = (m_count == 0);
                m_count = (m_count + MOD - 1) % MOD;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic apply_reset(input logic tick_lvl);
        rst               = 1'b1;
        sw_if.tick_in     = tick_lvl;
        sw_if.start_stop  = 1'b0;
        sw_if.clear       = 1'b0;
        sw_if.up_dn       = 1'b1;
        #2;
        step();
        rst     = 1'b0;
        m_count = 0;
        m_run   = 1'b0;
        m_wrap  = 1'b0;
    endtask

    task automatic pulse_ss();
        sw_if.start_stop = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        m_run  = !m_run;
        m_wrap = 1'b0;
    endtask

    task automatic pulse_clear();
        sw_if.clear = 1'b1;
        step();
        sw_if.clear = 1'b0;
        m_count = 0;
        m_run   = 1'b0;
        m_wrap  = 1'b0;
    endtask

    task automatic do_event(input int lo, input int hi);
        sw_if.tick_in = 1'b0;
        repeat (lo) step();
        sw_if.tick_in = 1'b1;
        step();
        model_count();
        if (hi > 1) begin
            repeat (hi - 1) step();
            m_wrap = 1'b0;
        end
    endtask

    task automatic event_with_ss();
        sw_if.tick_in = 1'b0;
        step();
        sw_if.tick_in    = 1'b1;
        sw_if.start_stop = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        model_count();
        m_run = !m_run;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        sw_if.tick_in    = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.up_dn      = 1'b1;
        #2;
        checks++;
        if (sw_if.bcd !== '0) begin
            errors++;
            $display("FAIL reset_bcd: got %h expected 0", sw_if.bcd);
        end
        checks++;
        if (sw_if.running !== 1'b0) begin
            errors++;
            $display("FAIL reset_running: got %b expected 0", sw_if.running);
        end
        checks++;
        if (sw_if.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b expected 0", sw_if.wrap);
        end
        checks++;
        if (sw_if.an !== 4'b1110) begin
            errors++;
            $display("FAIL reset_an: got %b expected 1110", sw_if.an);
        end
        checks++;
        if (sw_if.seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_seg: got %b expected 1000000", sw_if.seg);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_count_basic();
        apply_reset(1'b0);
        pulse_ss();
        for (int i = 0; i < 3; i++) do_event(50, 50);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL basic_bcd: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
        checks++;
        if (sw_if.running !== m_run) begin
            errors++;
            $display("FAIL basic_running: got %b expected %b",
                     sw_if.running, m_run);
        end
    endtask

    task automatic test_up_wrap();
        apply_reset(1'b0);
        pulse_ss();
        repeat (MOD - 1) do_event(1, 1);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL upwrap_preload: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
        do_event(1, 1);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL upwrap_bcd: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
        checks++;
        if (sw_if.wrap !== m_wrap) begin
            errors++;
            $display("FAIL upwrap_pulse: got %b expected %b",
                     sw_if.wrap, m_wrap);
        end
        step();
        checks++;
        if (sw_if.wrap !== 1'b0) begin
            errors++;
            $display("FAIL upwrap_len: got %b expected 0", sw_if.wrap);
        end
    endtask

    task automatic test_down_wrap();
        pulse_clear();
        pulse_ss();
        sw_if.up_dn = 1'b0;
        do_event(1, 1);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count) || sw_if.wrap !== m_wrap) begin
            errors++;
            $display("FAIL dnwrap: got %h/%b expected %h/%b",
                     sw_if.bcd, sw_if.wrap, to_bcd(m_count), m_wrap);
        end
        step();
        checks++;
        if (sw_if.wrap !== 1'b0) begin
            errors++;
            $display("FAIL dnwrap_len: got %b expected 0", sw_if.wrap);
        end
        do_event(1, 1);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count) || sw_if.wrap !== m_wrap) begin
            errors++;
            $display("FAIL dnwrap_next: got %h/%b expected %h/%b",
                     sw_if.bcd, sw_if.wrap, to_bcd(m_count), m_wrap);
        end
    endtask

    task automatic test_clear_priority();
        apply_reset(1'b0);
        pulse_ss();
        repeat (42) do_event(1, 2);
        sw_if.clear      = 1'b1;
        sw_if.start_stop = 1'b1;
        step();
        sw_if.clear      = 1'b0;
        sw_if.start_stop = 1'b0;
        m_count = 0;
        m_run   = 1'b0;
        m_wrap  = 1'b0;
        checks++;
        if (sw_if.bcd !== to_bcd(m_count) || sw_if.running !== m_run) begin
            errors++;
            $display("FAIL clear_prio: got %h/%b expected %h/%b",
                     sw_if.bcd, sw_if.running, to_bcd(m_count), m_run);
        end
        repeat (3) do_event(2, 2);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL clear_ignore: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
    endtask

    task automatic test_tick_high_reset();
        apply_reset(1'b1);
        repeat (3) step();
        pulse_ss();
        repeat (5) step();
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL tickhigh_hold: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
        do_event(2, 1);
        checks++;
        if (sw_if.bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL tickhigh_fresh: got %h expected %h",
                     sw_if.bcd, to_bcd(m_count));
        end
    endtask

    task automatic test_same_cycle();
        apply_reset(1'b0);
        event_with_ss();
        checks++;
        if (sw_if.bcd !== to_bcd(m_count) || sw_if.running !== m_run) begin
            errors++;
            $display("FAIL same_from_stop: got %h/%b expected %h/%b",
                     sw_if.bcd, sw_if.running, to_bcd(m_count), m_run);
        end
        do_event(1, 1);
        event_with_ss();
        checks++;
        if (sw_if.bcd !== to_bcd(m_count) || sw_if.running !== m_run) begin
            errors++;
            $display("FAIL same_from_run: got %h/%b expected %h/%b",
                     sw_if.bcd, sw_if.running, to_bcd(m_count), m_run);
        end
    endtask

    task automatic test_random();
        int op;
        apply_reset(1'b0);
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                do_event(int'($urandom_range(1, 3)), 1);
            end else if (op == 6) begin
                pulse_ss();
            end else if (op == 7) begin
                sw_if.up_dn = ~sw_if.up_dn;
                step();
                m_wrap = 1'b0;
            end else if (op == 8) begin
                event_with_ss();
            end else if ($urandom_range(0, 9) == 0) begin
                pulse_clear();
            end else begin
                do_event(1, 1);
            end
            checks++;
            if (sw_if.bcd !== to_bcd(m_count) ||
                sw_if.running !== m_run ||
                sw_if.wrap !== m_wrap) begin
                errors++;
                $display("FAIL random op%0d n%0d: got %h/%b/%b expected %h/%b/%b",
                         op, n, sw_if.bcd, sw_if.running, sw_if.wrap,
                         to_bcd(m_count), m_run, m_wrap);
            end
        end
    endtask

    task automatic test_scan();
        int k;
        int hi;
        logic [DIGITS-1:0] exp_an;
        logic [6:0]        exp_seg;
        apply_reset(1'b0);
        pulse_ss();
        repeat (107) do_event(1, 1);
        pulse_ss();
        step();
        for (int n = 0; n < 5 * SCAN_DIV * DIGITS; n++) begin
            k = (cyc == 0) ? 0 : ((cyc - 1) / SCAN_DIV) % DIGITS;
            exp_an = ~(DIGITS'(1) << k);
            hi = m_count / pow10(k);
            exp_seg = segtab[hi % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (k >= 1 && hi == 0) exp_seg = 7'b1111111;
`endif
            checks++;
            if (sw_if.an !== exp_an || sw_if.seg !== exp_seg) begin
                errors++;
                $display("FAIL scan cyc%0d: got %b/%b expected %b/%b",
                         cyc, sw_if.an, sw_if.seg, exp_an, exp_seg);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_count();
        apply_reset(1'b0);
        pulse_ss();
        repeat (5) do_event(1, 1);
        rst = 1'b1;
        #2;
        checks++;
        if (sw_if.bcd !== '0 || sw_if.running !== 1'b0 ||
            sw_if.an !== 4'b1110 || sw_if.seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_mid: got %h/%b/%b/%b expected 0/0/1110/1000000",
                     sw_if.bcd, sw_if.running, sw_if.an, sw_if.seg);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_basic();
        test_up_wrap();
        test_down_wrap();
        test_clear_priority();
        test_tick_high_reset();
        test_same_cycle();
        test_random();
        test_scan();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
